// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode enum and count-width helper for the sync FIFO
package fifo_pkg;
  typedef enum logic {FIFO_REG, FIFO_FWFT} fifo_mode_e;
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: WIDTH x DEPTH register array, one sync write port, one async read port
module fifo_mem_2p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: single-clock FIFO, any depth, registered or FWFT read,
// almost thresholds, synchronous flush and sticky overflow/underflow flags
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
  if (WIDTH < 1 || DEPTH < 2 || FWFT < 0 || FWFT > 1 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
    $error("sync_fifo_ext: illegal parameter combination");
  end
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf, r_udf;
  logic             w_wr_acc, w_rd_acc;
  logic [WIDTH-1:0] w_mem_q;
  assign empty        = r_count == '0;
  assign full         = r_count == CW'(DEPTH);
  assign almost_empty = r_count <= CW'(AE_THRESH);
  assign almost_full  = r_count >= CW'(AF_THRESH);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  // a full FIFO never accepts a write, even when a read frees a slot this cycle
  assign w_wr_acc = wr_req & ~full & ~flush;
  assign w_rd_acc = rd_req & ~empty & ~flush;
  always_ff @(posedge clk)
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      r_ovf   <= r_ovf | (wr_req & full);
      r_udf   <= r_udf | (rd_req & empty);
    end
  fifo_mem_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .i_we   (w_wr_acc),
    .i_waddr(r_wptr),
    .i_wdata(wr_data),
    .i_raddr(r_rptr),
    .o_rdata(w_mem_q)
  );
  if (MODE == FIFO_FWFT) begin : g_fwft
    assign rd_data = empty ? '0 : w_mem_q;
  end else begin : g_reg
    logic [WIDTH-1:0] r_rd_data;
    always_ff @(posedge clk)
      if (reset || flush) r_rd_data <= '0;
      else if (w_rd_acc) r_rd_data <= w_mem_q;
    assign rd_data = r_rd_data;
  end
endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb_sync_fifo_ext: directed checks on three FIFO configurations
module tb_sync_fifo_ext;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  // u0: defaults (DEPTH 4, registered read)
  logic fl0 = 0, wr0 = 0, rd0 = 0, em0, fu0, ae0, af0, ov0, un0;
  logic [7:0] wd0 = 0, q0;
  logic [2:0] cnt0;
  // u1: DEPTH 3, first-word-fall-through
  logic fl1 = 0, wr1 = 0, rd1 = 0, em1, fu1, ae1, af1, ov1, un1;
  logic [7:0] wd1 = 0, q1;
  logic [1:0] cnt1;
  // u2: DEPTH 5, registered read
  logic fl2 = 0, wr2 = 0, rd2 = 0, em2, fu2, ae2, af2, ov2, un2;
  logic [7:0] wd2 = 0, q2;
  logic [2:0] cnt2;

  sync_fifo_ext u0 (.clk(clk), .reset(rst), .flush(fl0), .wr_req(wr0), .wr_data(wd0), .rd_req(rd0),
    .rd_data(q0), .empty(em0), .full(fu0), .almost_empty(ae0), .almost_full(af0), .count(cnt0),
    .overflow(ov0), .underflow(un0));
  sync_fifo_ext #(.DEPTH(3), .FWFT(1)) u1 (.clk(clk), .reset(rst), .flush(fl1), .wr_req(wr1),
    .wr_data(wd1), .rd_req(rd1), .rd_data(q1), .empty(em1), .full(fu1), .almost_empty(ae1),
    .almost_full(af1), .count(cnt1), .overflow(ov1), .underflow(un1));
  sync_fifo_ext #(.DEPTH(5)) u2 (.clk(clk), .reset(rst), .flush(fl2), .wr_req(wr2), .wr_data(wd2),
    .rd_req(rd2), .rd_data(q2), .empty(em2), .full(fu2), .almost_empty(ae2), .almost_full(af2),
    .count(cnt2), .overflow(ov2), .underflow(un2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    checks++; if (em0 !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", em0); end
    checks++; if (fu0 !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fu0); end
    checks++; if (ae0 !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", ae0); end
    checks++; if (af0 !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", af0); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", q0); end
    checks++; if ({ov0, un0} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {ov0, un0}); end
    checks++; if ({em1, q1} !== 9'h100) begin errors++; $display("FAIL reset_fwft got=%h exp=100", {em1, q1}); end
    checks++; if ({em2, cnt2} !== 4'b1000) begin errors++; $display("FAIL reset_d5 got=%b exp=1000", {em2, cnt2}); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      wr0 = 1; wd0 = 8'hA1 + 8'(i);
      step();
      checks++; if (cnt0 !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, cnt0, i + 1); end
      checks++; if (af0 !== (i >= 2)) begin errors++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, af0, i >= 2); end
    end
    wr0 = 0;
    checks++; if (fu0 !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", fu0); end
    for (int i = 0; i < 4; i++) begin
      rd0 = 1;
      step();
      exp = 8'hA1 + 8'(i);
      checks++; if (q0 !== exp) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, q0, exp); end
      checks++; if (cnt0 !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, cnt0, 3 - i); end
    end
    rd0 = 0;
    checks++; if ({em0, ae0, fu0} !== 3'b110) begin errors++; $display("FAIL drain_status got=%b exp=110", {em0, ae0, fu0}); end
    checks++; if (un0 !== 1'b0) begin errors++; $display("FAIL drain_no_underflow got=%b exp=0", un0); end
  endtask

  task automatic test_fwft();
    wr1 = 1; wd1 = 8'h55;
    step();
    wr1 = 0;
    checks++; if (q1 !== 8'h55) begin errors++; $display("FAIL fwft_show got=%h exp=55", q1); end
    checks++; if (em1 !== 1'b0) begin errors++; $display("FAIL fwft_empty got=%b exp=0", em1); end
    rd1 = 1;
    step();
    rd1 = 0;
    checks++; if ({em1, q1} !== 9'h100) begin errors++; $display("FAIL fwft_pop got=%h exp=100", {em1, q1}); end
    for (int i = 0; i < 3; i++) begin
      wr1 = 1; wd1 = 8'h61 + 8'(i);
      step();
    end
    wr1 = 0;
    checks++; if ({fu1, af1, cnt1} !== 4'b1111) begin errors++; $display("FAIL fwft_full got=%b exp=1111", {fu1, af1, cnt1}); end
    checks++; if (q1 !== 8'h61) begin errors++; $display("FAIL fwft_head got=%h exp=61", q1); end
    rd1 = 1;
    step();
    rd1 = 0;
    checks++; if (q1 !== 8'h62) begin errors++; $display("FAIL fwft_next got=%h exp=62", q1); end
    fl1 = 1;
    step();
    fl1 = 0;
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin
      wr0 = 1; wd0 = 8'hB0 + 8'(i);
      step();
    end
    wd0 = 8'hEE; rd0 = 1;
    step();
    checks++; if (cnt0 !== 3'd3) begin errors++; $display("FAIL simul_count got=%0d exp=3", cnt0); end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL simul_overflow got=%b exp=1", ov0); end
    checks++; if (q0 !== 8'hB0) begin errors++; $display("FAIL simul_data got=%h exp=b0", q0); end
    wr0 = 0;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (q0 !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, q0, 8'hB0 + 8'(i)); end
    end
    rd0 = 0;
    checks++; if ({ov0, em0} !== 2'b11) begin errors++; $display("FAIL simul_sticky got=%b exp=11", {ov0, em0}); end
  endtask

  task automatic test_underflow_flush();
    rd0 = 1;
    step();
    rd0 = 0;
    checks++; if (un0 !== 1'b1) begin errors++; $display("FAIL udf_set got=%b exp=1", un0); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", cnt0); end
    checks++; if (q0 !== 8'hB3) begin errors++; $display("FAIL udf_hold got=%h exp=b3", q0); end
    fl0 = 1;
    step();
    fl0 = 0;
    checks++; if ({ov0, un0} !== 2'b00) begin errors++; $display("FAIL flush_flags got=%b exp=00", {ov0, un0}); end
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL flush_rd_data got=%h exp=00", q0); end
    wr0 = 1; wd0 = 8'h5A;
    step();
    wr0 = 0; rd0 = 1;
    step();
    rd0 = 0;
    checks++; if (q0 !== 8'h5A) begin errors++; $display("FAIL post_flush_data got=%h exp=5a", q0); end
  endtask

  task automatic test_wrap();
    logic [7:0] ref_q[$];
    logic [7:0] exp;
    for (int i = 0; i < 2; i++) begin
      wr2 = 1; wd2 = 8'h10 + 8'(i); ref_q.push_back(wd2);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      wr2 = 1; rd2 = 1; wd2 = 8'h20 + 8'(i);
      exp = ref_q.pop_front();
      ref_q.push_back(wd2);
      step();
      checks++; if (q2 !== exp) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, q2, exp); end
      checks++; if (cnt2 !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, cnt2); end
    end
    wr2 = 0; rd2 = 0;
  endtask

  task automatic test_flush_reset();
    rd1 = 1;
    step();
    rd1 = 0;
    checks++; if (un1 !== 1'b1) begin errors++; $display("FAIL fwft_udf got=%b exp=1", un1); end
    fl2 = 1; wr2 = 1; wd2 = 8'h99;
    step();
    fl2 = 0; wr2 = 0;
    checks++; if ({cnt2, em2, ov2, un2} !== 6'b000100) begin errors++; $display("FAIL flush_wr got=%b exp=000100", {cnt2, em2, ov2, un2}); end
    for (int i = 0; i < 2; i++) begin
      wr2 = 1; wd2 = 8'h77 + 8'(i);
      step();
    end
    wr2 = 0; rd2 = 1;
    step();
    rd2 = 0;
    checks++; if ({q2, cnt2} !== {8'h77, 3'd1}) begin errors++; $display("FAIL burst got=%h exp=771", {q2, cnt2}); end
    rst = 1; wr2 = 1; wd2 = 8'h88;
    step();
    rst = 0; wr2 = 0;
    checks++; if ({q2, cnt2, em2, fu2, ae2, af2} !== {8'h00, 3'd0, 4'b1010}) begin errors++; $display("FAIL reset_mid got=%h exp=%h", {q2, cnt2, em2, fu2, ae2, af2}, {8'h00, 3'd0, 4'b1010}); end
    checks++; if ({un1, em1, q1} !== 10'h100) begin errors++; $display("FAIL reset_fwft got=%h exp=100", {un1, em1, q1}); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_fwft();
    test_full_simul();
    test_underflow_flush();
    test_wrap();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
